// File: rtl/dat_seq_ctrl.sv
// Burst reader / serialiser: on a start edge, reads `count` words from a data
// block at base + k*step and sends each as a 10-bit UART-style frame on txd.
module dat_seq_ctrl #(
  parameter int unsigned DIV    = 50,  // clocks per serial bit, 2..65535
  parameter int unsigned TO_MAX = 255  // rd_ack wait limit is TO_MAX+1 cycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [3:0] base_i,
  input  logic [3:0] step_i,
  input  logic [7:0] count_i,
  output logic       rd_req_o,
  output logic [7:0] rd_addr_o,
  input  logic       rd_ack_i,
  input  logic [7:0] rd_data_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] word_cnt_o
);

  localparam logic [15:0] TmrLast  = 16'(DIV - 1);
  localparam logic [15:0] WaitLast = 16'(TO_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic        arm_q, arm_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic        err_q, err_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] tmr_q, tmr_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  frame_q, frame_d;

  logic start_edge;
  logic bit_tick;
  logic frame_end;
  logic last_word;
  logic timeout;

  // arm_q masks the first cycle after reset so a start held through reset is not an edge
  assign start_edge = start_i & ~start_q & arm_q;
  assign bit_tick   = (tmr_q == TmrLast);
  assign frame_end  = bit_tick && (bit_q == 4'd9);
  assign last_word  = ((word_cnt_q + 8'd1) == count_q);
  assign timeout    = (wait_q == WaitLast);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = (count_i == 8'd0) ? StDone : StReq;
        end
      end
      StReq: begin
        // an ack in the timeout cycle still wins
        if (rd_ack_i) begin
          state_d = StShift;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StShift: begin
        if (frame_end) begin
          state_d = last_word ? StDone : StReq;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    rd_req_o   = (state_q == StReq);
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
    txd_o      = (state_q == StShift) ? frame_q[0] : 1'b1;
    rd_addr_o  = addr_q;
    err_o      = err_q;
    word_cnt_o = word_cnt_q;
  end

  // Datapath next-state: burst parameters, address, timers and frame shifter
  always_comb begin
    start_d    = start_i;
    arm_d      = 1'b1;
    addr_d     = addr_q;
    step_d     = step_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    wait_d     = wait_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          addr_d     = {4'b0000, base_i};
          step_d     = step_i;
          count_d    = count_i;
          word_cnt_d = 8'd0;
          err_d      = 1'b0;
          wait_d     = 16'd0;
        end
      end
      StReq: begin
        if (rd_ack_i) begin
          frame_d = {1'b1, rd_data_i, 1'b0};
          tmr_d   = 16'd0;
          bit_d   = 4'd0;
          // next word's address is prepared while this one shifts out
          addr_d  = addr_q + {4'b0000, step_q};
        end else if (timeout) begin
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StShift: begin
        if (bit_tick) begin
          tmr_d   = 16'd0;
          frame_d = {1'b1, frame_q[9:1]};
          if (bit_q == 4'd9) begin
            bit_d      = 4'd0;
            word_cnt_d = word_cnt_q + 8'd1;
            wait_d     = 16'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      StDone: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      arm_q      <= 1'b0;
      addr_q     <= 8'd0;
      step_q     <= 4'd0;
      count_q    <= 8'd0;
      word_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      wait_q     <= 16'd0;
      tmr_q      <= 16'd0;
      bit_q      <= 4'd0;
      frame_q    <= 10'h3ff;
    end else begin
      start_q    <= start_d;
      arm_q      <= arm_d;
      addr_q     <= addr_d;
      step_q     <= step_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
    end
  end

endmodule

// File: tb/tb_dat_seq_ctrl.sv
// Bench for dat_seq_ctrl: per-cycle comparison against a burst-level model,
// plus fixed-value expectations for the directed scenarios.
module tb_dat_seq_ctrl;

  localparam int DIV    = 4;
  localparam int TO_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base, step;
  logic [7:0] count;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       txd, busy, done, err;
  logic [7:0] word_cnt;

  dat_seq_ctrl #(.DIV(DIV), .TO_MAX(TO_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .base_i    (base),
    .step_i    (step),
    .count_i   (count),
    .rd_req_o  (rd_req),
    .rd_addr_o (rd_addr),
    .rd_ack_i  (rd_ack),
    .rd_data_i (rd_data),
    .txd_o     (txd),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model: mode 0 idle, 1 waiting for a word, 2 sending a frame, 3 burst end
  int         m_mode, m_base, m_step, m_count, m_k, m_wait, m_c, m_wc;
  bit         m_prev, m_err;
  logic [9:0] m_frame;

  // Observation log for directed scenarios
  int addr_log[$];
  int done_cnt = 0, busy_cyc = 0, req_cyc = 0;

  // Responder: 0 never acks, 1 acks one cycle after rd_req, 2 random latency 0..20
  int ack_mode = 1;
  int lat_cnt = 0, lat_tgt = 1;
  bit scramble = 0;
  bit err_at_accept;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle_check();
    bit edge_seen;
    if (!rst_n) begin
      m_mode = 0; m_prev = 1'b1; m_err = 0; m_wc = 0; m_c = 0; m_wait = 0; m_k = 0;
      chk("rst_rd_addr", rd_addr, 0);
    end
    chk("rd_req", rd_req, (m_mode == 1) ? 1 : 0);
    if (m_mode == 1) chk("rd_addr", rd_addr, (m_base + m_k * m_step) % 256);
    chk("txd", txd, (m_mode == 2) ? m_frame[m_c / DIV] : 1);
    chk("busy", busy, (m_mode != 0) ? 1 : 0);
    chk("done", done, (m_mode == 3) ? 1 : 0);
    chk("err", err, m_err);
    chk("word_cnt", word_cnt, m_wc);
    if (rd_req && rd_ack) addr_log.push_back(int'(rd_addr));
    if (rd_req) req_cyc++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (rst_n) begin
      edge_seen = start && !m_prev;
      m_prev = start;
      case (m_mode)
        0: if (edge_seen) begin
          m_base = base; m_step = step; m_count = count;
          m_err = 0; m_wc = 0; m_k = 0; m_wait = 0;
          m_mode = (count == 0) ? 3 : 1;
        end
        1: if (rd_ack) begin
          m_frame = {1'b1, rd_data, 1'b0}; m_c = 0; m_mode = 2;
        end else if (m_wait == TO_MAX) begin
          m_err = 1; m_mode = 3;
        end else m_wait++;
        2: if (m_c == 10 * DIV - 1) begin
          m_wc++; m_k++;
          if (m_k == m_count) m_mode = 3;
          else begin m_mode = 1; m_wait = 0; end
        end else m_c++;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic respond();
    rd_data = 8'($urandom);
    if (rd_req && ack_mode != 0) begin
      if (lat_cnt >= lat_tgt) begin
        rd_ack = 1; lat_cnt = 0;
        lat_tgt = (ack_mode == 1) ? 1 : $urandom_range(0, 20);
      end else begin
        rd_ack = 0; lat_cnt++;
      end
    end else begin
      rd_ack = 0; lat_cnt = 0;
    end
  endtask

  // One clock: check at negedge, then drive responder just after posedge
  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    respond();
    if (scramble) begin
      base = 4'($urandom); step = 4'($urandom); count = 8'($urandom);
      if ($urandom_range(0, 7) == 0) start = ~start;
    end
  endtask

  // Runs one burst; glitch_at >= 0 re-pulses start that many cycles in
  task automatic run_burst(input int b, input int s, input int n, input int glitch_at);
    int i;
    base = 4'(b); step = 4'(s); count = 8'(n);
    start = 1;
    tick();
    err_at_accept = err;
    start = 0;
    for (i = 0; i < 20000 && busy; i++) begin
      if (i == glitch_at) start = 1;
      if (i == glitch_at + 2) start = 0;
      tick();
    end
    if (busy) begin
      nchk++; nerr++;
      $display("FAIL burst_end: busy still %0d after 20000 cycles, expected 0", busy);
    end
    scramble = 0;
    start = 0;
    tick();
  endtask

  int a0, d0, b0, r0;

  initial begin
    rst_n = 0; start = 0; base = 0; step = 0; count = 0; rd_ack = 0; rd_data = 0;
    tick();
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    tick();
    #2 rst_n = 1;
    repeat (3) tick();

    // Three words, fixed one-cycle ack latency
    a0 = addr_log.size(); d0 = done_cnt; b0 = busy_cyc;
    run_burst(4'hA, 4, 3, -1);
    chk("s1_addr_n", addr_log.size() - a0, 3);
    if (addr_log.size() - a0 == 3) begin
      chk("s1_addr0", addr_log[a0], 8'h0A);
      chk("s1_addr1", addr_log[a0 + 1], 8'h0E);
      chk("s1_addr2", addr_log[a0 + 2], 8'h12);
    end
    chk("s1_word_cnt", word_cnt, 3);
    chk("s1_done", done_cnt - d0, 1);
    chk("s1_err", err, 0);
    chk("s1_busy_cycles", busy_cyc - b0, 127);

    // Empty burst
    a0 = addr_log.size(); d0 = done_cnt; b0 = busy_cyc; r0 = req_cyc;
    run_burst(3, 1, 0, -1);
    chk("s2_req_cycles", req_cyc - r0, 0);
    chk("s2_busy_cycles", busy_cyc - b0, 1);
    chk("s2_done", done_cnt - d0, 1);

    // Address wrap-around
    a0 = addr_log.size(); b0 = busy_cyc;
    run_burst(4'hF, 4'hF, 18, -1);
    chk("s3_last_addr", addr_log[addr_log.size() - 1], 8'h0E);
    chk("s3_word_cnt", word_cnt, 18);
    chk("s3_busy_cycles", busy_cyc - b0, 757);

    // Timeout, then err clears on the next accepted start
    ack_mode = 0;
    d0 = done_cnt; r0 = req_cyc;
    run_burst(1, 1, 5, -1);
    chk("s4_err", err, 1);
    chk("s4_req_cycles", req_cyc - r0, 16);
    chk("s4_word_cnt", word_cnt, 0);
    chk("s4_done", done_cnt - d0, 1);
    ack_mode = 1;
    run_burst(2, 2, 1, -1);
    chk("s4_err_clear", err_at_accept, 0);

    // Start edge during SHIFT is ignored
    d0 = done_cnt; b0 = busy_cyc;
    run_burst(0, 1, 2, 10);
    chk("s5_word_cnt", word_cnt, 2);
    chk("s5_done", done_cnt - d0, 1);
    chk("s5_busy_cycles", busy_cyc - b0, 85);

    // Asynchronous reset mid-data-bit, start held high through it
    base = 4'h5; step = 1; count = 3;
    start = 1;
    repeat (12) tick();
    d0 = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("s6_async_txd", txd, 1);
    chk("s6_async_busy", busy, 0);
    chk("s6_async_done", done, 0);
    tick();
    tick();
    #2 rst_n = 1;
    b0 = busy_cyc;
    repeat (6) tick();
    chk("s6_no_done", done_cnt - d0, 0);
    chk("s6_held_start_busy", busy_cyc - b0, 0);
    start = 0;
    tick();

    // Randomized bursts with random latency and input churn mid-burst
    ack_mode = 2;
    for (int n = 0; n < 8; n++) begin
      scramble = (n % 2) == 1;
      run_burst($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 5), -1);
    end
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dat_seq_ctrl.md
DAT_SEQ_CTRL -- requirements
Module: dat_seq_ctrl

Interface
REQ-001 Parameter DIV, default 50: clocks per serial bit time; legal range 2..65535.
REQ-002 Parameter TO_MAX, default 255: maximum rd_ack wait in clocks before timeout.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  raw start level from the button; rising edge detected internally.
REQ-006 base  in  4  first word address, zero-extended to 8 bits.
REQ-007 step  in  4  address increment per word, zero-extended.
REQ-008 count  in  8  number of words per burst (N); 0 means empty burst.
REQ-009 rd_req  out  1  data-block read request.
REQ-010 rd_addr  out  8  data-block read address.
REQ-011 rd_ack  in  1  data-block acknowledge; rd_data valid in the same cycle.
REQ-012 rd_data  in  8  data-block read word.
REQ-013 txd  out  1  serial output; idle high.
REQ-014 busy  out  1  high from leaving IDLE until return to IDLE.
REQ-015 done  out  1  one-cycle pulse at burst end.
REQ-016 err  out  1  sticky timeout flag; cleared by the next accepted start.
REQ-017 word_cnt  out  8  words fully transmitted in the current or last burst (display source).

Function
REQ-018 Start edge: start is registered once; edge = start & ~start_q; a single edge is accepted only in IDLE, and edges while busy are ignored.
REQ-019 On an accepted edge in cycle t, the FSM samples base/step/count into internal registers, clears word_cnt and err, and enters REQ at t+1 (busy=1, rd_req=1).
REQ-020 FSM states: IDLE, REQ, SHIFT, DONE; transitions IDLE->REQ (edge, count!=0), IDLE->DONE (edge, count==0), REQ->SHIFT (rd_ack), REQ->DONE (timeout), SHIFT->REQ (stop bit ends, words left), SHIFT->DONE (stop bit ends, last word), DONE->IDLE (always, one cycle).
REQ-021 Address for word k (k=0..N-1) = base + k*step mod 256; 8-bit wrap-around, no saturation.
REQ-022 In REQ, rd_req stays high and rd_addr stays stable until rd_ack is sampled high; rd_req is low in the cycle after the ack and in all non-REQ states.
REQ-023 On ack, rd_data is latched into a 10-bit frame register {1, data[7:0], 0}, and the bit timer is cleared.
REQ-024 In SHIFT, txd = frame[0]; every DIV clocks the frame shifts right by one; a frame lasts exactly 10*DIV clocks (start 0, data LSB first, stop 1).
REQ-025 word_cnt increments at the end of each stop bit and wraps at 256 only if count wraps (N<=255, so it never wraps).
REQ-026 Timeout: a wait counter clears on entry to REQ; if rd_ack is not seen within TO_MAX+1 cycles, err is set, the FSM goes to DONE, and the remaining words are abandoned.
REQ-027 If rd_ack is high in the cycle the timeout is reached, the ack wins.
REQ-028 done=1 only in DONE; busy=0 in IDLE only; txd=1 outside SHIFT.
REQ-029 Input changes on base/step/count during a burst have no effect until the next accepted start.

Reset
REQ-030 rst_n low forces immediately: FSM=IDLE, rd_req=0, rd_addr=0, txd=1, busy=0, done=0, err=0, word_cnt=0, and all counters and start_q =0.
REQ-031 Reset mid-frame aborts the burst with no done pulse; after release, a fresh start edge is required (a start held high through reset is not an edge).

Verification (DIV=4, TO_MAX=15)
REQ-032 base=0xA, step=4, count=3, rd_ack one cycle after rd_req -> rd_addr 0x0A, 0x0E, 0x12 in order; three 40-clock frames on txd matching rd_data; word_cnt=3; one done pulse; err=0.
REQ-033 count=0 -> no rd_req, done pulse at t+1 after the edge, busy high for exactly 1 cycle, txd constant 1.
REQ-034 base=0xF, step=0xF, count=18 -> last rd_addr = 0x0E (270 mod 256); word_cnt=18.
REQ-035 rd_ack held 0 -> err=1 and done after 16 REQ cycles; word_cnt=0; err clears on the next start.
REQ-036 Second start edge during SHIFT -> ignored, burst length unchanged; rst_n pulsed low mid-data-bit -> txd=1 and busy=0 asynchronously, no done pulse.
